clock_timekeeper: RTL

- Time-of-day and alarm register stage directly downstream of the mode/increment control FSM.
- Consumes the FSM's state code and its four single-purpose increment strobes.
- Maintains HH:MM:SS from an internal 1 Hz prescaler and holds the alarm HH:MM setting.
- Drives a ringing output to the display/buzzer stage.

---
 rtl/clock_timekeeper.sv | 122 ++++++++++++
 1 files changed

// File: rtl/clock_timekeeper.sv
// Time-of-day and alarm registers behind the mode/increment FSM: 1 Hz prescaler,
// HH:MM:SS with carry, alarm HH:MM setting, and a self-clearing alarm ring.
module clock_timekeeper #(
    parameter int CLK_HZ    = 100000000,
    parameter int RING_SECS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       inc_alarm_hour,
    input  logic       inc_alarm_min,
    input  logic       alarm_en,
    input  logic       alarm_stop,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       tick_1hz,
    output logic       alarm_ring
);

    typedef enum logic [2:0] {
        NORMAL,
        SET_HOUR,
        SET_MIN,
        SET_ALARM_HOUR,
        SET_ALARM_MIN
    } mode_e;

    localparam int             PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_HZ - 1);
    localparam logic [7:0]     RING_LAST = 8'(RING_SECS);

    logic [PW-1:0] pre_cnt;
    logic [7:0]    ring_cnt;
    logic          tick_now;
    logic          advance;
    logic          trigger;
    logic          ring_expire;
    logic [4:0]    hour_nxt;
    logic [5:0]    min_nxt;
    logic [5:0]    sec_nxt;
    logic [4:0]    alarm_hour_nxt;
    logic [5:0]    alarm_min_nxt;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latches).
    always_comb begin
        tick_now       = (pre_cnt == PRE_LAST);
        // A manual time increment in the same cycle swallows the tick's update.
        advance        = tick_now && (state == NORMAL) && !inc_hour && !inc_min;
        hour_nxt       = hour;
        min_nxt        = min;
        sec_nxt        = sec;
        alarm_hour_nxt = alarm_hour;
        alarm_min_nxt  = alarm_min;

        if (advance) begin
            if (sec == 6'd59) begin
                sec_nxt = 6'd0;
                if (min == 6'd59) begin
                    min_nxt  = 6'd0;
                    hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                end else begin
                    min_nxt = min + 6'd1;
                end
            end else begin
                sec_nxt = sec + 6'd1;
            end
        end else begin
            if (inc_hour) hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            if (inc_min) begin
                min_nxt = (min == 6'd59) ? 6'd0 : min + 6'd1;
                sec_nxt = 6'd0;
            end
        end

        if (inc_alarm_hour) alarm_hour_nxt = (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
        if (inc_alarm_min)  alarm_min_nxt  = (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;

        trigger     = advance && alarm_en && (sec_nxt == 6'd0) &&
                      (hour_nxt == alarm_hour) && (min_nxt == alarm_min);
        ring_expire = alarm_ring && tick_now && (ring_cnt + 8'd1 == RING_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt    <= '0;
            tick_1hz   <= 1'b0;
            hour       <= '0;
            min        <= '0;
            sec        <= '0;
            alarm_hour <= '0;
            alarm_min  <= '0;
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
        end else begin
            pre_cnt    <= tick_now ? '0 : pre_cnt + 1'b1;
            tick_1hz   <= tick_now;
            hour       <= hour_nxt;
            min        <= min_nxt;
            sec        <= sec_nxt;
            alarm_hour <= alarm_hour_nxt;
            alarm_min  <= alarm_min_nxt;

            // Silencing beats a same-cycle trigger; a retrigger restarts the ring count.
            if (alarm_stop || !alarm_en) begin
                alarm_ring <= 1'b0;
            end else if (trigger) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= '0;
            end else if (alarm_ring && tick_now) begin
                ring_cnt <= ring_cnt + 8'd1;
                if (ring_expire) alarm_ring <= 1'b0;
            end
        end
    end

endmodule
